// File: rtl/fb_access_scheduler.sv
// Frame-buffer access scheduler: display reads win every cycle; host writes are
// queued in a FIFO and retired in idle cycles; a clear sweep fills the memory.
// Optional macro FB_STALL_STATS_EN adds a saturating blocked-write counter.
module fb_access_scheduler #(
  parameter int AW         = 15,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_WORDS  = 19200
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_rd_req,
  input  logic [AW-1:0]                 i_rd_addr,
  output logic [DW-1:0]                 o_rd_data,
  output logic                          o_rd_valid,
  input  logic                          i_wr_valid,
  output logic                          o_wr_ready,
  input  logic [AW-1:0]                 i_wr_addr,
  input  logic [DW-1:0]                 i_wr_data,
  input  logic                          i_clr_start,
  input  logic [DW-1:0]                 i_clr_data,
  output logic                          o_clr_busy,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [AW-1:0]                 o_mem_addr,
  output logic [DW-1:0]                 o_mem_wdata,
  input  logic [DW-1:0]                 i_mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
`ifdef FB_STALL_STATS_EN
  input  logic                          i_stall_clr,
  output logic [15:0]                   o_stall_cnt,
`endif
  output logic                          o_dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  // Handshake: a host write transfers on a rising clock edge when
  // i_wr_valid && o_wr_ready; o_wr_ready depends only on the registered level.

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q;
  logic [DW-1:0]   fill_q;
  logic            rd_valid_q;

  logic [AW-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DW-1:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;

  logic            fifo_empty;
  logic            push, pop;
  logic            clr_wr;
  logic            clr_last;
  logic            clr_go;

  assign fifo_empty   = (level_q == '0);
  assign o_wr_ready   = (level_q != LW'(FIFO_DEPTH));
  assign push         = i_wr_valid && o_wr_ready;
  assign clr_last     = (clr_cnt_q == AW'(MEM_WORDS - 1));
  assign clr_go       = (state_q == S_IDLE) && i_clr_start;

  assign o_rd_data    = i_mem_rdata;
  assign o_rd_valid   = rd_valid_q;
  assign o_clr_busy   = (state_q == S_CLEAR);
  assign o_fifo_level = level_q;
  assign o_dbg_state  = state_q;

  // Arbitration: read > clear write > FIFO write.
  always_comb begin
    state_d     = state_q;
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    pop         = 1'b0;
    clr_wr      = 1'b0;
    if (i_rd_req) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_rd_addr;
    end else begin
      case (state_q)
        S_CLEAR: begin
          o_mem_en    = 1'b1;
          o_mem_we    = 1'b1;
          o_mem_addr  = clr_cnt_q;
          o_mem_wdata = fill_q;
          clr_wr      = 1'b1;
        end
        default: begin
          if (!fifo_empty) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = fifo_addr[rd_ptr_q];
            o_mem_wdata = fifo_data[rd_ptr_q];
            pop         = 1'b1;
          end
        end
      endcase
    end
    case (state_q)
      S_IDLE:  if (i_clr_start) state_d = S_CLEAR;
      S_CLEAR: if (clr_wr && clr_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      fill_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= i_rd_req;
      if (clr_go) begin
        clr_cnt_q <= '0;
        fill_q    <= i_clr_data;
      end else if (clr_wr) begin
        clr_cnt_q <= clr_last ? '0 : clr_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Payload storage needs no reset; the pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_addr[wr_ptr_q] <= i_wr_addr;
      fifo_data[wr_ptr_q] <= i_wr_data;
    end
  end

`ifdef FB_STALL_STATS_EN
  logic        stall;
  logic [15:0] stall_cnt_q;

  assign stall       = i_rd_req && ((state_q == S_CLEAR) || !fifo_empty);
  assign o_stall_cnt = stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stall_cnt_q <= '0;
    end else if (i_stall_clr) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fb_access_scheduler.md
Name: fb_access_scheduler

Overview:
Shares one single-port synchronous frame-buffer RAM between the display read path and a host write path, all in the pixel clock domain. Display reads take absolute priority. Host writes are queued in a small FIFO and retired in cycles with no read. A clear-screen sequencer fills the whole memory with a constant using the same idle cycles.

Parameters:
AW, 15, memory word address width
DW, 16, memory word width (16 one-bit pixels per word)
FIFO_DEPTH, 4, host write FIFO entries (power of two, >=2)
MEM_WORDS, 19200, words swept by clear (640x480/16)

Ports:
i_clk  in  1  pixel clock
i_rstn  in  1  asynchronous active-low reset
i_rd_req  in  1  display read request this cycle
i_rd_addr  in  AW  display read address
o_rd_data  out  DW  read data (pass-through of i_mem_rdata)
o_rd_valid  out  1  o_rd_data valid, one cycle after the accepted i_rd_req
i_wr_valid  in  1  host write request
o_wr_ready  out  1  FIFO can accept
i_wr_addr  in  AW  host write address
i_wr_data  in  DW  host write data
i_clr_start  in  1  pulse: start clear sweep
i_clr_data  in  DW  fill value, sampled on accepted start
o_clr_busy  out  1  clear sweep in progress
o_mem_en  out  1  RAM enable
o_mem_we  out  1  RAM write enable
o_mem_addr  out  AW  RAM address
o_mem_wdata  out  DW  RAM write data
i_mem_rdata  in  DW  RAM read data (1-cycle latency)
o_fifo_level  out  clog2(FIFO_DEPTH)+1  entries queued

Behaviour:
- Clock and reset: i_clk, single domain. Reset is asynchronous and active-low on i_rstn.
- Reset values: FIFO empty, o_fifo_level=0, o_wr_ready=1, o_rd_valid=0, o_clr_busy=0, state IDLE, clear counter 0, fill register 0.
- o_mem_* are combinational from the arbitration decision and current state. In cycles with nothing to do: o_mem_en=0, o_mem_we=0, addr/wdata=0.
- Priority per cycle: read > clear write > FIFO write.
- Read cycle (i_rd_req=1): en=1, we=0, addr=i_rd_addr. o_rd_valid=1 on the next cycle. o_rd_data=i_mem_rdata, unregistered.
- States:
  - IDLE: pops the FIFO head to RAM (en=1, we=1) in any cycle with i_rd_req=0 and the FIFO not empty.
  - IDLE -> CLEAR: on i_clr_start=1. Latch i_clr_data, counter=0, o_clr_busy=1 from the next cycle.
  - CLEAR: each cycle with i_rd_req=0 writes the fill value at the counter address and increments the counter. FIFO is not drained during CLEAR but keeps accepting pushes.
  - CLEAR -> IDLE: after the write at address MEM_WORDS-1. Counter returns to 0; o_clr_busy=0 on the following cycle.
- i_clr_start while in CLEAR is ignored; the sweep does not restart.
- FIFO:
  - o_wr_ready = (level != FIFO_DEPTH), combinational from the registered level.
  - Push when i_wr_valid && o_wr_ready.
  - Push and pop in the same cycle leaves the level unchanged. Push into the last free slot makes ready=0 next cycle.
  - Pointers wrap modulo FIFO_DEPTH. Ordering is strictly first-in first-out.
- A write to an address being read in the same cycle cannot occur, because a read blocks all writes that cycle.
- Host writes queued before a clear retire after it and overwrite the fill value. Clear does not flush the FIFO.
- Reset asserted mid-sweep or with the FIFO non-empty: all queued writes are discarded, the sweep aborts, and outputs return to their reset values immediately.

Optional Feature:
FB_STALL_STATS_EN
- Defined:
  - Adds output o_stall_cnt, 16 bits.
  - Counts cycles where a pending write (FIFO non-empty in IDLE, or in CLEAR) is blocked by i_rd_req=1.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by input i_stall_clr (1 bit, synchronous, also added).
- Not defined: neither port exists and the counter logic is absent. All other behaviour is identical.

Test Plan:
1. Reset release, no stimulus -> o_wr_ready=1, o_fifo_level=0, o_clr_busy=0, o_mem_en=0 for 10 cycles.
2. i_rd_req=1 with addr 0x0123, RAM model returns 0xBEEF -> next cycle o_rd_valid=1, o_rd_data=0xBEEF. o_mem_we never 1 while i_rd_req=1.
3. Push 5 writes back-to-back with i_rd_req=1 held -> 4 accepted, o_wr_ready=0, level=4. Drop i_rd_req -> 4 RAM writes on 4 consecutive cycles, in order. Fifth write accepted once ready=1.
4. Clear with fill 0xFFFF and MEM_WORDS=8 override, i_rd_req toggling 1/0 -> exactly 8 writes to addresses 0..7, each value 0xFFFF. o_clr_busy high through the last write, low the cycle after. Second i_clr_start mid-sweep has no effect.
5. Queue writes to addr 3 (0x0000) before a clear of fill 0xAAAA -> final RAM[3]=0x0000, written after the sweep completes.
6. Assert i_rstn=0 mid-clear with 2 FIFO entries -> o_clr_busy=0, level=0, o_mem_en=0 immediately. After release, no stale writes are issued.
